// File: rtl/cmd_pwm_driver.sv
// Differential PWM motor driver: speed/steer mixing, period-aligned duty, reversal dead time.
// Optional command watchdog (sticky fault + forced OFF) is built when CMD_WDT_EN is defined.
module cmd_pwm_driver #(
  parameter int CMD_L   = 4,
  parameter int CENTER  = 8,
  parameter int PRESC   = 4,
  parameter int DEAD_T  = 8,
  parameter int WDT_CYC = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CMD_L-1:0] speed_cmd,
  input  logic [CMD_L-1:0] dir_cmd,
  input  logic             cmd_stb,
  output logic             pwm_l,
  output logic             pwm_r,
  output logic             dir_l,
  output logic             dir_r,
  output logic             period_sync,
  output logic             fault
);

  localparam int MAX = 2**CMD_L - 1;
  localparam int MW  = CMD_L + 2;
  localparam int PW  = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int DW  = (DEAD_T > 0) ? $clog2(DEAD_T + 1) : 1;
  localparam logic signed [MW-1:0] CENTER_S = MW'(CENTER);

  typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_DEAD} state_t;
  typedef struct packed {
    logic             dir;
    logic [CMD_L-1:0] mag;
  } req_t;

  // Sign becomes the direction request; magnitude saturates at full scale.
  function automatic req_t mix_sat(input logic signed [MW-1:0] v);
    req_t       r;
    logic [MW-1:0] a;
    a     = v[MW-1] ? $unsigned(-v) : $unsigned(v);
    r.dir = v[MW-1];
    r.mag = (a > MW'(MAX)) ? CMD_L'(MAX) : a[CMD_L-1:0];
    return r;
  endfunction

  logic [PW-1:0]    r_presc;
  logic [CMD_L-1:0] r_pwm_cnt;
  logic             r_period_sync;
  logic             w_tick;
  logic             w_boundary;

  assign w_tick     = (r_presc == PW'(PRESC - 1));
  assign w_boundary = w_tick && (r_pwm_cnt == CMD_L'(MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc       <= '0;
      r_pwm_cnt     <= '0;
      r_period_sync <= 1'b0;
    end else begin
      // NOTE: state uses <= so every register samples pre-edge values; = here would chain updates.
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) r_pwm_cnt <= w_boundary ? '0 : r_pwm_cnt + 1'b1;
      r_period_sync <= w_boundary;
    end
  end

  logic signed [MW-1:0] w_speed;
  logic signed [MW-1:0] w_diff;
  logic signed [MW-1:0] w_mix_l;
  logic signed [MW-1:0] w_mix_r;
  req_t                 w_req [2];

  always_comb begin
    w_speed  = signed'(MW'(speed_cmd));
    w_diff   = signed'(MW'(dir_cmd)) - CENTER_S;
    w_mix_l  = w_speed + w_diff;
    w_mix_r  = w_speed - w_diff;
    w_req[0] = mix_sat(w_mix_l);
    w_req[1] = mix_sat(w_mix_r);
  end

  logic w_force_off;

`ifdef CMD_WDT_EN
  localparam int WW = $clog2(WDT_CYC + 1);

  logic [WW-1:0] r_wdt;
  logic          r_fault;
  logic          w_trip;

  // Trip on the same edge the count reaches WDT_CYC so drive is cut without extra latency.
  assign w_trip = en && !cmd_stb && (r_wdt == WW'(WDT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdt   <= '0;
      r_fault <= 1'b0;
    end else begin
      if (cmd_stb || !en)            r_wdt <= '0;
      else if (r_wdt != WW'(WDT_CYC)) r_wdt <= r_wdt + 1'b1;
      if (cmd_stb)     r_fault <= 1'b0;
      else if (w_trip) r_fault <= 1'b1;
    end
  end

  assign w_force_off = r_fault || w_trip;
  assign fault       = r_fault;
`else
  logic w_unused;

  assign w_unused    = cmd_stb | (WDT_CYC < 1);
  assign w_force_off = 1'b0;
  assign fault       = 1'b0;
`endif

  logic w_run_ok;

  assign w_run_ok = en && !w_force_off;

  state_t           r_state    [2];
  logic [CMD_L-1:0] r_duty     [2];
  logic             r_dir      [2];
  logic             r_req_dir  [2];
  logic [DW-1:0]    r_dead_cnt [2];
  logic             r_pwm      [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_state[i]    <= ST_OFF;
        r_duty[i]     <= '0;
        r_dir[i]      <= 1'b0;
        r_req_dir[i]  <= 1'b0;
        r_dead_cnt[i] <= '0;
        r_pwm[i]      <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_pwm[i] <= w_run_ok && (r_state[i] == ST_RUN) && (r_pwm_cnt < r_duty[i]);
        if (w_boundary) r_req_dir[i] <= w_req[i].dir;

        if (!w_run_ok) begin
          r_state[i] <= ST_OFF;
          r_duty[i]  <= '0;
        end else begin
          case (r_state[i])
            ST_OFF: begin
              // A pending reversal enters RUN dark and takes the dead-time path next period.
              if (w_boundary) begin
                r_state[i] <= ST_RUN;
                r_duty[i]  <= (w_req[i].dir == r_dir[i] || w_req[i].mag == '0) ? w_req[i].mag : '0;
              end
            end
            ST_RUN: begin
              if (w_boundary) begin
                if (w_req[i].dir == r_dir[i] || w_req[i].mag == '0) begin
                  r_duty[i] <= w_req[i].mag;
                end else begin
                  r_state[i]    <= ST_DEAD;
                  r_dead_cnt[i] <= DW'(DEAD_T);
                  r_duty[i]     <= '0;
                end
              end
            end
            ST_DEAD: begin
              if (r_dead_cnt[i] <= DW'(1)) begin
                r_dir[i]      <= r_req_dir[i];
                r_state[i]    <= ST_RUN;
                r_dead_cnt[i] <= '0;
              end else begin
                r_dead_cnt[i] <= r_dead_cnt[i] - 1'b1;
              end
            end
            default: r_state[i] <= ST_OFF;
          endcase
        end
      end
    end
  end

  assign pwm_l       = r_pwm[0];
  assign pwm_r       = r_pwm[1];
  assign dir_l       = r_dir[0];
  assign dir_r       = r_dir[1];
  assign period_sync = r_period_sync;

endmodule

// File: tb/tb_cmd_pwm_driver.sv
// Directed bench for cmd_pwm_driver: per-period PWM high counts, dead time, enable and reset.
// Watchdog expectations switch on CMD_WDT_EN.
module tb_cmd_pwm_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] speed_cmd = '0;
  logic [3:0] dir_cmd = 4'd8;
  logic       stb_req = 1'b0;
  logic       stb_auto = 1'b1;
  logic       auto_pulse = 1'b0;
  wire        cmd_stb;
  logic       pwm_l, pwm_r, dir_l, dir_r, period_sync, fault;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  assign cmd_stb = auto_pulse | stb_req;

  cmd_pwm_driver dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .speed_cmd  (speed_cmd),
    .dir_cmd    (dir_cmd),
    .cmd_stb    (cmd_stb),
    .pwm_l      (pwm_l),
    .pwm_r      (pwm_r),
    .dir_l      (dir_l),
    .dir_r      (dir_r),
    .period_sync(period_sync),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // Periodic command strobe, as the upstream controller would issue.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      auto_pulse = stb_auto && (cyc % 50 == 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_pwm_l"}, int'(pwm_l), 0);
    check({tag, "_pwm_r"}, int'(pwm_r), 0);
    check({tag, "_dir_l"}, int'(dir_l), 0);
    check({tag, "_dir_r"}, int'(dir_r), 0);
    check({tag, "_sync"},  int'(period_sync), 0);
    check({tag, "_fault"}, int'(fault), 0);
  endtask

  task automatic wait_sync(output int n);
    n = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (period_sync) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic apply(input logic [3:0] s, input logic [3:0] d, input logic e);
    speed_cmd = s;
    dir_cmd   = d;
    en        = e;
  endtask

  // Starts on a period_sync negedge, observes the 60 clocks of one PWM period and ends on the next.
  // exp_flip: first cycle (1..60) with dir_r high, 99 if it stays low.
  task automatic win(input string tag, input int chg_at, input logic [3:0] s, input logic [3:0] d,
                     input logic e, input int exp_l, input int exp_r, input int exp_flip);
    int nl, nr, ndl, nsync, flip, last;
    nl = 0; nr = 0; ndl = 0; nsync = 0; flip = 99; last = 0;
    if (chg_at == 0) apply(s, d, e);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      nl    += int'(pwm_l);
      nr    += int'(pwm_r);
      ndl   += int'(dir_l);
      nsync += int'(period_sync);
      last   = int'(period_sync);
      if (dir_r && flip == 99) flip = c;
      if (c == chg_at) apply(s, d, e);
    end
    check({tag, "_pwm_l_hi"}, nl, exp_l);
    check({tag, "_pwm_r_hi"}, nr, exp_r);
    check({tag, "_dir_r_hi_at"}, flip, exp_flip);
    check({tag, "_dir_l_hi"}, ndl, 0);
    check({tag, "_sync_cnt"}, nsync, 1);
    check({tag, "_sync_at60"}, last, 1);
  endtask

  initial begin
    int n, first_f, pl;

    // Reset state
    apply(4'd5, 4'd8, 1'b1);
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    wait_sync(n);
    check("rst_to_sync", n, 60);

    // 1: straight ahead at 5/15
    win("t1a", 0, 4'd5, 4'd8, 1'b1, 20, 20, 99);
    win("t1b", 0, 4'd5, 4'd8, 1'b1, 20, 20, 99);

    // 2: steer right, left saturates
    win("t2_old", 0, 4'd12, 4'd12, 1'b1, 20, 20, 99);
    win("t2",     0, 4'd12, 4'd12, 1'b1, 60, 32, 99);

    // 3: mid-period steer change reverses the right wheel
    win("t3_old",  0,  4'd2, 4'd8,  1'b1, 60, 32, 99);
    win("t3_a",    0,  4'd2, 4'd8,  1'b1, 8,  8,  99);
    win("t3_mid",  20, 4'd2, 4'd15, 1'b1, 8,  8,  99);
    win("t3_dead", 0,  4'd2, 4'd15, 1'b1, 36, 0,  8);
    win("t3_rev",  0,  4'd2, 4'd15, 1'b1, 36, 20, 1);

    // 4: en dropped 3 clks into dead time, then reasserted
    rst = 1'b1;
    apply(4'd2, 4'd8, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_sync(n);
    check("t4_rst_to_sync", n, 60);
    win("t4_pre",  20, 4'd2, 4'd15, 1'b1, 8,  8,  99);
    win("t4_drop", 2,  4'd2, 4'd15, 1'b0, 2,  0,  99);
    win("t4_off",  0,  4'd2, 4'd15, 1'b1, 0,  0,  99);
    win("t4_run",  0,  4'd2, 4'd15, 1'b1, 36, 0,  99);
    win("t4_dead", 0,  4'd2, 4'd15, 1'b1, 36, 0,  8);
    win("t4_rev",  0,  4'd2, 4'd15, 1'b1, 36, 20, 1);

    // 5: zero speed keeps direction; reset mid-period
    win("t5_old", 0, 4'd0,  4'd8, 1'b1, 36, 20, 1);
    win("t5_zero", 0, 4'd0, 4'd8, 1'b1, 0,  0,  1);
    win("t5_set", 0, 4'd10, 4'd8, 1'b1, 0,  0,  1);
    repeat (4) @(negedge clk);
    check("t5_pre_pwm_l", int'(pwm_l), 1);
    check("t5_pre_dir_r", int'(dir_r), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("t5_rst");
    rst = 1'b0;
    wait_sync(n);
    check("t5_rst_to_sync", n, 60);
    win("t5_after", 0, 4'd10, 4'd8, 1'b1, 40, 40, 99);

    // 6: no command strobes for well over the watchdog timeout
    rst = 1'b1;
    stb_auto = 1'b0;
    apply(4'd5, 4'd8, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    first_f = -1;
    pl = 0;
    for (int k = 1; k <= 1100; k++) begin
      @(negedge clk);
      if (fault) begin
        first_f = k;
        pl = int'(pwm_l | pwm_r);
        break;
      end
    end
`ifdef CMD_WDT_EN
    check("t6_fault_at", first_f, 1000);
    check("t6_pwm_forced", pl, 0);
    stb_req = 1'b1;
    @(negedge clk);
    stb_req = 1'b0;
    check("t6_fault_clr", int'(fault), 0);
`else
    check("t6_no_fault", first_f, -1);
`endif
    wait_sync(n);
    check("t6_sync_seen", int'(n > 0), 1);
    win("t6_run", 0, 4'd5, 4'd8, 1'b1, 20, 20, 99);
`ifndef CMD_WDT_EN
    check("t6_fault_end", int'(fault), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
